// File: rtl/axi4_frame_mem_slave_pkg.sv
// axi4_mem_pkg: shared FSM state types and AXI response/burst encodings
package axi4_mem_pkg;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
endpackage

// File: rtl/axi4_frame_mem_slave_rd_skid.sv
// axi_rd_skid: 2-entry valid/ready FIFO decoupling the 1-cycle RAM read from the R channel
module axi_rd_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  logic         pop;
  assign valid_o = cnt_q != 2'd0;
  assign data_o = valid_o ? mem_q[rp_q] : '0;
  assign cnt_o = cnt_q;
  assign pop = valid_o && ready_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (valid_i) begin
        mem_q[wp_q] <= data_i;
        wp_q <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + 2'(valid_i) - 2'(pop);
    end
  end
endmodule

// File: rtl/axi4_frame_mem_slave.sv
// axi4_frame_mem_slave: AXI4 INCR/FIXED burst slave on inferred byte-enable RAM; AXI_SLV_STALL_EN adds LFSR ready/issue stalls
module axi4_frame_mem_slave import axi4_mem_pkg::*; #(
  parameter int ASIZE = 29,
  parameter int AXI_DSIZE = 256,
  parameter int IDSIZE = 4,
  parameter int BURST_LEN_SIZE = 8,
  parameter int MEM_AW = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IDSIZE-1:0]         axi_awid,
  input  logic [ASIZE-1:0]          axi_awaddr,
  input  logic [BURST_LEN_SIZE-1:0] axi_awlen,
  input  logic [2:0]                axi_awsize,
  input  logic [1:0]                axi_awburst,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [AXI_DSIZE-1:0]      axi_wdata,
  input  logic [AXI_DSIZE/8-1:0]    axi_wstrb,
  input  logic                      axi_wlast,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  output logic [IDSIZE-1:0]         axi_bid,
  output logic [1:0]                axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  input  logic [IDSIZE-1:0]         axi_arid,
  input  logic [ASIZE-1:0]          axi_araddr,
  input  logic [BURST_LEN_SIZE-1:0] axi_arlen,
  input  logic [2:0]                axi_arsize,
  input  logic [1:0]                axi_arburst,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  output logic [IDSIZE-1:0]         axi_rid,
  output logic [AXI_DSIZE-1:0]      axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rlast,
  output logic                      axi_rvalid,
  input  logic                      axi_rready
);
  localparam int BYTES = AXI_DSIZE / 8;
  localparam int BW = $clog2(BYTES);
  localparam int CW = BURST_LEN_SIZE + 1;
  logic [AXI_DSIZE-1:0]      mem_q [2**MEM_AW];
  logic [AXI_DSIZE-1:0]      rd_q;
  w_state_t                  w_state_q;
  r_state_t                  r_state_q;
  logic [IDSIZE-1:0]         w_id_q, b_id_q, r_id_q;
  logic [MEM_AW-1:0]         w_idx_q, r_idx_q;
  logic [BURST_LEN_SIZE-1:0] w_len_q, r_len_q;
  logic [CW-1:0]             w_cnt_q, r_cnt_q;
  logic                      w_fixed_q, w_err_q, r_fixed_q, r_err_q;
  logic [1:0]                b_resp_q, skid_cnt;
  logic                      r_infl_q, r_infl_last_q, skid_valid;
  logic                      stall, aw_hs, w_hs, w_we, ar_hs, r_pop, r_issue, r_issue_last;
  logic                      unused_addr;
`ifdef AXI_SLV_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = lfsr_q[1:0] == 2'b00;
`else
  assign stall = 1'b0;
`endif
  assign unused_addr = ^{axi_awaddr, axi_araddr};
  assign axi_awready = !rst && !stall && w_state_q == W_IDLE;
  assign axi_wready = !rst && !stall && w_state_q == W_DATA;
  assign axi_bvalid = !rst && w_state_q == W_RESP;
  assign axi_bid = b_id_q;
  assign axi_bresp = b_resp_q;
  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs = axi_wvalid && axi_wready;
  assign w_we = w_hs && w_cnt_q <= {1'b0, w_len_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_id_q <= '0;
      w_idx_q <= '0;
      w_len_q <= '0;
      w_cnt_q <= '0;
      w_fixed_q <= 1'b0;
      w_err_q <= 1'b0;
      b_id_q <= '0;
      b_resp_q <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_hs) begin
          w_id_q <= axi_awid;
          w_idx_q <= axi_awaddr[BW+:MEM_AW];
          w_len_q <= axi_awlen;
          w_fixed_q <= axi_awburst == BURST_FIXED;
          w_err_q <= axi_awsize != 3'(BW);
          w_cnt_q <= '0;
          w_state_q <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_idx_q <= w_fixed_q ? w_idx_q : w_idx_q + 1'b1;
          w_cnt_q <= w_cnt_q + CW'(w_cnt_q <= {1'b0, w_len_q});
          if (axi_wlast) begin
            b_id_q <= w_id_q;
            b_resp_q <= (w_err_q || w_cnt_q != {1'b0, w_len_q}) ? RESP_SLVERR : RESP_OKAY;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (axi_bready) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (w_we)
      for (int b = 0; b < BYTES; b++)
        if (axi_wstrb[b]) mem_q[w_idx_q][8*b+:8] <= axi_wdata[8*b+:8];
  end
  always_ff @(posedge clk) rd_q <= mem_q[r_idx_q];
  assign axi_arready = !rst && !stall && r_state_q == R_IDLE;
  assign ar_hs = axi_arvalid && axi_arready;
  assign axi_rvalid = !rst && skid_valid;
  assign r_pop = axi_rvalid && axi_rready;
  assign r_issue = r_state_q == R_DATA && !stall && r_cnt_q <= {1'b0, r_len_q}
                   && 3'(skid_cnt) + 3'(r_infl_q) <= 3'd1 + 3'(r_pop);
  assign r_issue_last = r_cnt_q == {1'b0, r_len_q};
  assign axi_rid = r_id_q;
  assign axi_rresp = r_err_q ? RESP_SLVERR : RESP_OKAY;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_id_q <= '0;
      r_idx_q <= '0;
      r_len_q <= '0;
      r_cnt_q <= '0;
      r_fixed_q <= 1'b0;
      r_err_q <= 1'b0;
      r_infl_q <= 1'b0;
      r_infl_last_q <= 1'b0;
    end else begin
      r_infl_q <= r_issue;
      r_infl_last_q <= r_issue && r_issue_last;
      case (r_state_q)
        R_IDLE: if (ar_hs) begin
          r_id_q <= axi_arid;
          r_idx_q <= axi_araddr[BW+:MEM_AW];
          r_len_q <= axi_arlen;
          r_fixed_q <= axi_arburst == BURST_FIXED;
          r_err_q <= axi_arsize != 3'(BW);
          r_cnt_q <= '0;
          r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (r_issue) begin
            r_idx_q <= r_fixed_q ? r_idx_q : r_idx_q + 1'b1;
            r_cnt_q <= r_cnt_q + 1'b1;
          end
          if (r_pop && axi_rlast) r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end
  axi_rd_skid #(.W(AXI_DSIZE + 1)) u_skid (
    .clk(clk),
    .rst(rst),
    .valid_i(r_infl_q),
    .data_i({r_infl_last_q, rd_q}),
    .ready_i(axi_rready),
    .valid_o(skid_valid),
    .data_o({axi_rlast, axi_rdata}),
    .cnt_o(skid_cnt)
  );
endmodule

// File: tb/tb_axi4_frame_mem_slave.sv
// tb_axi4_frame_mem_slave: directed AXI write/read bursts with immediate-assertion checks
module tb_axi4_frame_mem_slave;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   awid = '0, arid = '0, bid, rid;
  logic [28:0]  awaddr = '0, araddr = '0;
  logic [7:0]   awlen = '0, arlen = '0;
  logic [2:0]   awsize = 3'd5, arsize = 3'd5;
  logic [1:0]   awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic         awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic         bvalid, bready = 1'b0, arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
  logic [255:0] wdata = '0, rdata;
  logic [31:0]  wstrb = '1;
  int           checks = 0, failures = 0;
  logic [255:0] got_d [16];
  logic         got_l [16];
  logic [1:0]   got_r [16];
  logic [3:0]   got_id [16];
  int           got_c [16];
  int           n_got, lat;
  logic [1:0]   w_resp;
  logic [3:0]   w_bid;
  always #5 clk = ~clk;
  axi4_frame_mem_slave dut (
    .clk(clk), .rst(rst),
    .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
    .axi_awburst(awburst), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
    .axi_arburst(arburst), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
    .axi_rvalid(rvalid), .axi_rready(rready)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL timeout %s observed=stuck expected=handshake", tag);
  endtask
  task automatic wr(input logic [3:0] id, input logic [28:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [2:0] size, input int nb, input int base);
    logic s;
    int t;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    t = 0;
    do begin s = awready; tick(); t++; end while (!s && t < 50);
    if (!s) timeout("aw");
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wdata = 256'(base + i); wlast = (i == nb - 1); wvalid = 1'b1;
      t = 0;
      do begin s = wready; tick(); t++; end while (!s && t < 50);
      if (!s) timeout("w");
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    do begin s = bvalid; w_resp = bresp; w_bid = bid; tick(); t++; end while (!s && t < 50);
    if (!s) timeout("b");
    bready = 1'b0;
  endtask
  task automatic rd(input logic [3:0] id, input logic [28:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [2:0] size, input logic toggle, input string tag);
    logic s, v, l, rr, prev_stall;
    logic [255:0] d, prev_d;
    int t, cyc;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    t = 0;
    do begin s = arready; tick(); t++; end while (!s && t < 50);
    if (!s) timeout("ar");
    arvalid = 1'b0;
    n_got = 0; lat = -1; cyc = 0; prev_stall = 1'b0; prev_d = '0;
    while (n_got < 16 && cyc < 100) begin
      rr = toggle ? (cyc % 2 == 0) : 1'b1;
      rready = rr;
      v = rvalid; d = rdata; l = rlast;
      if (v && lat < 0) lat = cyc;
      if (prev_stall) chk({tag, "_hold"}, d, prev_d);
      if (v && rr) begin
        got_d[n_got] = d; got_l[n_got] = l; got_r[n_got] = rresp; got_id[n_got] = rid; got_c[n_got] = cyc;
      end
      tick();
      if (v && rr) begin
        n_got++;
        if (l) break;
      end
      prev_stall = v && !rr; prev_d = d; cyc++;
    end
    if (cyc >= 100) timeout({tag, "_r"});
    rready = 1'b0;
  endtask
  initial begin
    tick();
    chk("rst_awready", 256'(awready), 256'(0));
    chk("rst_arready", 256'(arready), 256'(0));
    chk("rst_bvalid", 256'(bvalid), 256'(0));
    chk("rst_rvalid", 256'(rvalid), 256'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("idle_awready", 256'(awready), 256'(1));
    chk("idle_arready", 256'(arready), 256'(1));
    chk("idle_wready", 256'(wready), 256'(0));
    chk("idle_bresp", 256'(bresp), 256'(0));
    wr(4'd5, 29'h40, 8'd3, 2'b01, 3'd5, 4, 1);
    chk("wr1_bresp", 256'(w_resp), 256'(0));
    chk("wr1_bid", 256'(w_bid), 256'(5));
    rd(4'd9, 29'h40, 8'd3, 2'b01, 3'd5, 1'b0, "rd1");
    chk("rd1_n", 256'(n_got), 256'(4));
    chk("rd1_lat", 256'(lat), 256'(2));
    for (int i = 0; i < 4; i++) begin
      chk("rd1_data", got_d[i], 256'(i + 1));
      chk("rd1_last", 256'(got_l[i]), 256'(i == 3));
      chk("rd1_cyc", 256'(got_c[i]), 256'(i + 2));
    end
    chk("rd1_rid", 256'(got_id[0]), 256'(9));
    chk("rd1_rresp", 256'(got_r[0]), 256'(0));
    chk("rd1_arready_after", 256'(arready), 256'(1));
    wr(4'd1, 29'h100, 8'd3, 2'b01, 3'd5, 4, 'hA0);
    wr(4'd2, 29'h100, 8'd3, 2'b01, 3'd5, 2, 'h11);
    chk("short_bresp", 256'(w_resp), 256'(2));
    rd(4'd0, 29'h100, 8'd3, 2'b01, 3'd5, 1'b0, "rd_short");
    chk("rd_short_0", got_d[0], 256'h11);
    chk("rd_short_1", got_d[1], 256'h12);
    chk("rd_short_2", got_d[2], 256'hA2);
    chk("rd_short_3", got_d[3], 256'hA3);
    wr(4'd3, 29'h280, 8'd1, 2'b01, 3'd5, 2, 'hB0);
    wr(4'd4, 29'h200, 8'd3, 2'b01, 3'd5, 6, 'h21);
    chk("long_bresp", 256'(w_resp), 256'(2));
    chk("long_bid", 256'(w_bid), 256'(4));
    rd(4'd0, 29'h200, 8'd5, 2'b01, 3'd5, 1'b0, "rd_long");
    chk("rd_long_n", 256'(n_got), 256'(6));
    chk("rd_long_3", got_d[3], 256'h24);
    chk("rd_long_4", got_d[4], 256'hB0);
    chk("rd_long_5", got_d[5], 256'hB1);
    rd(4'd7, 29'h40, 8'd3, 2'b01, 3'd5, 1'b1, "rd_tog");
    chk("rd_tog_n", 256'(n_got), 256'(4));
    for (int i = 0; i < 4; i++) chk("rd_tog_data", got_d[i], 256'(i + 1));
    chk("rd_tog_last", 256'(got_l[3]), 256'(1));
    wr(4'd0, 29'h300, 8'd1, 2'b01, 3'd5, 2, 'hC0);
    wr(4'd6, 29'h300, 8'd2, 2'b00, 3'd5, 3, 'h31);
    chk("fixed_bresp", 256'(w_resp), 256'(0));
    rd(4'd0, 29'h300, 8'd1, 2'b01, 3'd5, 1'b0, "rd_fixw");
    chk("fixed_w0", got_d[0], 256'h33);
    chk("fixed_w1", got_d[1], 256'hC1);
    rd(4'd0, 29'h40, 8'd2, 2'b00, 3'd5, 1'b0, "rd_fixr");
    chk("fixed_r_n", 256'(n_got), 256'(3));
    for (int i = 0; i < 3; i++) chk("fixed_r_data", got_d[i], 256'h1);
    wr(4'd0, 29'h7FE0, 8'd1, 2'b01, 3'd5, 2, 'h41);
    chk("wrap_bresp", 256'(w_resp), 256'(0));
    rd(4'd0, 29'h0, 8'd0, 2'b01, 3'd5, 1'b0, "rd_wrap0");
    chk("wrap_idx0", got_d[0], 256'h42);
    chk("len0_n", 256'(n_got), 256'(1));
    chk("len0_last", 256'(got_l[0]), 256'(1));
    rd(4'd0, 29'h7FE0, 8'd1, 2'b01, 3'd5, 1'b0, "rd_wrap");
    chk("wrap_r0", got_d[0], 256'h41);
    chk("wrap_r1", got_d[1], 256'h42);
    wr(4'd0, 29'h3C0, 8'd0, 2'b01, 3'd4, 1, 'h55);
    chk("size_bresp", 256'(w_resp), 256'(2));
    rd(4'd0, 29'h3C0, 8'd0, 2'b01, 3'd5, 1'b0, "rd_size_ok");
    chk("size_written", got_d[0], 256'h55);
    chk("size_ok_rresp", 256'(got_r[0]), 256'(0));
    rd(4'd0, 29'h3C0, 8'd0, 2'b01, 3'd4, 1'b0, "rd_size_err");
    chk("size_err_rresp", 256'(got_r[0]), 256'(2));
    rd(4'd0, 29'h100040, 8'd0, 2'b01, 3'd5, 1'b0, "rd_alias");
    chk("alias_data", got_d[0], 256'h1);
    araddr = 29'h40; arlen = 8'd3; arburst = 2'b01; arsize = 3'd5; arvalid = 1'b1;
    chk("mr_arready", 256'(arready), 256'(1));
    tick();
    arvalid = 1'b0; rready = 1'b0;
    tick();
    tick();
    chk("mr_rvalid_pre", 256'(rvalid), 256'(1));
    rst = 1'b1;
    tick();
    chk("mr_rvalid_rst", 256'(rvalid), 256'(0));
    chk("mr_arready_rst", 256'(arready), 256'(0));
    rst = 1'b0;
    tick();
    chk("mr_arready_post", 256'(arready), 256'(1));
    chk("mr_rvalid_post", 256'(rvalid), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
